neopixel_refresh_ctrl: RTL

Sequences a frame refresh of a WS2812-style LED chain from the 256x24-bit pixel memory. On a start request it walks a contiguous range of pixel-memory read addresses. It latches each 24-bit colour word and serialises it MSB-first as WS2812 pulse-width-coded bits on a single output pin. It closes the frame with a low latch/reset period, then signals completion. It drives the memory read port only; it never writes the memory.

---
 rtl/neopixel_refresh_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/neopixel_refresh_ctrl.sv
// rtl/neopixel_refresh_ctrl.sv - WS2812 frame refresh sequencer reading a 256x24 pixel memory
module neopixel_refresh_ctrl #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63,
  parameter int TRST = 3000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [7:0]  i_count,
  output logic [7:0]  o_rs_addr,
  input  logic [23:0] i_rs_data,
  output logic        o_dout,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRST_LAST = CW'(TRST - 1);
  localparam logic [CW-1:0] T0H_C     = CW'(T0H);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_LATCH, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     base_q, base_d;
  logic [7:0]     count_q, count_d;
  logic [7:0]     pix_q, pix_d;
  logic [7:0]     addr_q, addr_d;
  logic [23:0]    sh_q, sh_d;
  logic [4:0]     bit_q, bit_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           dout_q, dout_d;
  logic           done_q;
  logic [7:0]     pix_inc;

  assign pix_inc = pix_q + 8'd1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    pix_d   = pix_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          count_d = i_count;
          pix_d   = 8'd0;
          cyc_d   = '0;
          state_d = (i_count == 8'd0) ? S_LATCH : S_LOAD;
        end
      end
      S_LOAD: begin
        sh_d    = i_rs_data;
        bit_d   = 5'd23;
        cyc_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cyc_q == TBIT_LAST) begin
          cyc_d = '0;
          if (bit_q != 5'd0) begin
            sh_d  = {sh_q[22:0], 1'b0};
            bit_d = bit_q - 5'd1;
          end else begin
            pix_d   = pix_inc;
            state_d = (pix_inc == count_q) ? S_LATCH : S_LOAD;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cyc_q == TRST_LAST) begin
          cyc_d   = '0;
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address and line level are computed for the upcoming cycle so both are registered
  // yet the memory sees the address during LOAD and the first high lands right after it.
  always_comb begin
    addr_d = (state_d == S_LOAD) ? (base_d + pix_d) : addr_q;
    dout_d = (state_d == S_SEND) && (cyc_d < (sh_d[23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      base_q  <= 8'd0;
      count_q <= 8'd0;
      pix_q   <= 8'd0;
      addr_q  <= 8'd0;
      sh_q    <= 24'd0;
      bit_q   <= 5'd0;
      cyc_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      dout_q  <= dout_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  assign o_rs_addr = addr_q;
  assign o_dout    = dout_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;

endmodule
